seq_checker: RTL and testbench
==============================

// Module: seq_checker
// PURPOSE
//  Sink-side integrity checker for the incrementing-counter test pattern that feeds the hsdaoh FIFO.
//  Sits on the async FIFO read port in the clk_pixel domain and snoops the FIFO read strobe and read data.
//  Runs in parallel with hsdaoh_core.
//  Tracks the data stream, locks to the +1 sequence and counts sequence errors (dropped or corrupted words).
//  Exposes lock status, error and word counters, and a snapshot of the last error for debug.
// PARAMETERS
//  DSIZE       16  data word width; the sequence wraps modulo 2^DSIZE
//  RD_LATENCY  1   cycles from rd_en to valid rd_data (0..3); 1 matches a non-fallthrough FIFO
//  LOCK_COUNT  8   consecutive in-sequence words required to enter LOCK (>=2)
//  LOSS_COUNT  4   consecutive mismatches in LOCK that drop back to HUNT (>=1)
//  CNT_W       32  width of err_count and word_count
// PORTS
//  clk_pixel   in   1           checker clock (FIFO read clock)
//  rstn        in   1           asynchronous active-low reset
//  clear       in   1           synchronous clear of counters, snapshot and state
//  rd_en       in   1           FIFO read strobe (same signal driven into the FIFO rinc)
//  rd_data     in   DSIZE       FIFO read data, valid RD_LATENCY cycles after rd_en
//  locked      out  1           1 while state is LOCK
//  err_count   out  CNT_W       sequence errors seen in LOCK; saturating
//  word_count  out  CNT_W       all valid words seen, in any state; saturating
//  err_pulse   out  1           one-cycle pulse per counted error
//  last_exp    out  DSIZE       expected value at the most recent counted error
//  last_got    out  DSIZE       received value at the most recent counted error
// BEHAVIOUR
//  Reset (rstn=0, asynchronous):
//   - all outputs 0; state=HUNT; valid pipeline, exp, run and miss cleared.
//  Valid qualification:
//   - vld = rd_en delayed by RD_LATENCY through a flop chain; RD_LATENCY=0 means vld=rd_en.
//   - d = rd_data sampled when vld=1. Cycles with vld=0 change nothing.
//  Match rule:
//   - match = (d == exp); exp is DSIZE bits and wraps, so 0xFFFF followed by 0x0000 is a match.
//   - Every processed word sets exp <= d+1 (resync on every word, so a single drop costs one error).
//  State machine (all updates registered on vld):
//   - HUNT: set run<=1, exp<=d+1, then go to ACQ.
//   - ACQ, match: run<=run+1; if run+1==LOCK_COUNT then go to LOCK, set miss<=0.
//   - ACQ, mismatch: run<=1 and stay in ACQ. Not counted as an error.
//   - LOCK, match: miss<=0.
//   - LOCK, mismatch: err_count++, err_pulse=1 next cycle, last_exp<=exp, last_got<=d, miss<=miss+1.
//   - LOCK, mismatch, miss+1==LOSS_COUNT: go to HUNT.
//  Outputs and timing:
//   - locked is registered from the state; it rises the cycle after the LOCK_COUNT-th in-sequence word is processed.
//   - word_count increments on every vld in any state.
//   - Both counters hold at all-ones; they never wrap.
//   - err_pulse is high for exactly one cycle per counted error; back-to-back errors give consecutive pulses.
//  clear:
//   - Zeros the counters and last_* and sets state=HUNT; locked=0 next cycle.
//   - The vld pipeline is not flushed.
//   - clear has priority over a simultaneous vld; that word is discarded and not counted.
//  Reset mid-stream:
//   - Outputs go to 0 immediately; words still in flight in the valid pipeline are lost.
//   - After release, the first valid word is processed from HUNT.
// TESTING
//  1. RD_LATENCY=1; rd_en held high; words 0..19 -> locked=1 after word 7 is processed, err_count=0, word_count=20.
//  2. Stream 0xFFF8..0x0007 (16 words, across the wrap) -> locked=1, err_count=0, word_count=16.
//  3. Locked; send 0x00FF, 0x0101, 0x0102 -> err_count=1, one err_pulse, last_exp=0x0100, last_got=0x0101, locked stays 1.
//  4. Locked; send 4 random non-sequential words -> err_count=4, locked=0 after the 4th. Then 8 sequential words -> locked=1, err_count still 4.
//  5. rd_en toggling every other cycle; words 0..19 -> same counts as test 1; no spurious errors on idle cycles.
//  6. clear asserted together with vld -> counters=0, locked=0, word discarded. rstn pulse mid-stream -> all outputs 0 asynchronously.
//  7. CNT_W=4; 20 errors -> err_count saturates at 0xF.

Source files
------------

// File: rtl/seq_checker.sv
// Sink-side checker for the incrementing-counter test pattern on the FIFO read port.
// Locks onto the +1 sequence, counts dropped/corrupted words and keeps a snapshot of the last error.
module seq_checker #(
   parameter int unsigned DSIZE      = 16,
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned LOCK_COUNT = 8,
   parameter int unsigned LOSS_COUNT = 4,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk_pixel,
   input  logic             rstn,
   input  logic             clear,
   input  logic             rd_en,
   input  logic [DSIZE-1:0] rd_data,
   output logic             locked,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] word_count,
   output logic             err_pulse,
   output logic [DSIZE-1:0] last_exp,
   output logic [DSIZE-1:0] last_got
);

   localparam int unsigned RUN_W  = $clog2(LOCK_COUNT + 1);
   localparam int unsigned MISS_W = $clog2(LOSS_COUNT + 1);

   typedef enum logic [1:0] {
      ST_HUNT,
      ST_ACQ,
      ST_LOCK
   } state_e;

   logic vld;

   generate
      if (RD_LATENCY == 0) begin : g_lat0
         assign vld = rd_en;
      end else begin : g_pipe
         logic [RD_LATENCY-1:0] vld_pipe_q;
         logic [RD_LATENCY-1:0] vld_pipe_d;

         always_comb begin
            vld_pipe_d[0] = rd_en;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
               vld_pipe_d[i] = vld_pipe_q[i-1];
            end
         end

         // Only reset flushes the pipeline; clear leaves words in flight.
         always_ff @(posedge clk_pixel or negedge rstn) begin
            if (!rstn) begin
               vld_pipe_q <= '0;
            end else begin
               vld_pipe_q <= vld_pipe_d;
            end
         end

         assign vld = vld_pipe_q[RD_LATENCY-1];
      end
   endgenerate

   state_e             state_q, state_d;
   logic [DSIZE-1:0]   exp_q, exp_d;
   logic [RUN_W-1:0]   run_q, run_d;
   logic [MISS_W-1:0]  miss_q, miss_d;
   logic [CNT_W-1:0]   err_count_q, err_count_d;
   logic [CNT_W-1:0]   word_count_q, word_count_d;
   logic               err_pulse_q, err_pulse_d;
   logic               locked_q, locked_d;
   logic [DSIZE-1:0]   last_exp_q, last_exp_d;
   logic [DSIZE-1:0]   last_got_q, last_got_d;
   logic               match;

   assign match = (rd_data == exp_q);

   always_comb begin
      state_d      = state_q;
      exp_d        = exp_q;
      run_d        = run_q;
      miss_d       = miss_q;
      err_count_d  = err_count_q;
      word_count_d = word_count_q;
      err_pulse_d  = 1'b0;
      last_exp_d   = last_exp_q;
      last_got_d   = last_got_q;

      if (clear) begin
         state_d      = ST_HUNT;
         exp_d        = '0;
         run_d        = '0;
         miss_d       = '0;
         err_count_d  = '0;
         word_count_d = '0;
         last_exp_d   = '0;
         last_got_d   = '0;
      end else if (vld) begin
         // Resync on every word so a single dropped word costs exactly one error.
         exp_d = rd_data + DSIZE'(1);
         if (word_count_q != '1) begin
            word_count_d = word_count_q + CNT_W'(1);
         end
         case (state_q)
            ST_HUNT: begin
               run_d   = RUN_W'(1);
               state_d = ST_ACQ;
            end
            ST_ACQ: begin
               if (match) begin
                  run_d = run_q + RUN_W'(1);
                  if (run_d == RUN_W'(LOCK_COUNT)) begin
                     state_d = ST_LOCK;
                     miss_d  = '0;
                  end
               end else begin
                  run_d = RUN_W'(1);
               end
            end
            ST_LOCK: begin
               if (match) begin
                  miss_d = '0;
               end else begin
                  if (err_count_q != '1) begin
                     err_count_d = err_count_q + CNT_W'(1);
                  end
                  err_pulse_d = 1'b1;
                  last_exp_d  = exp_q;
                  last_got_d  = rd_data;
                  miss_d      = miss_q + MISS_W'(1);
                  if (miss_d == MISS_W'(LOSS_COUNT)) begin
                     state_d = ST_HUNT;
                  end
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end
   end

   assign locked_d = (state_d == ST_LOCK);

   always_ff @(posedge clk_pixel or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_HUNT;
         exp_q        <= '0;
         run_q        <= '0;
         miss_q       <= '0;
         err_count_q  <= '0;
         word_count_q <= '0;
         err_pulse_q  <= 1'b0;
         locked_q     <= 1'b0;
         last_exp_q   <= '0;
         last_got_q   <= '0;
      end else begin
         state_q      <= state_d;
         exp_q        <= exp_d;
         run_q        <= run_d;
         miss_q       <= miss_d;
         err_count_q  <= err_count_d;
         word_count_q <= word_count_d;
         err_pulse_q  <= err_pulse_d;
         locked_q     <= locked_d;
         last_exp_q   <= last_exp_d;
         last_got_q   <= last_got_d;
      end
   end

   assign locked     = locked_q;
   assign err_count  = err_count_q;
   assign word_count = word_count_q;
   assign err_pulse  = err_pulse_q;
   assign last_exp   = last_exp_q;
   assign last_got   = last_got_q;

endmodule

// File: tb/tb_seq_checker.sv
// Scoreboard bench for seq_checker: a 32-bit-counter instance and a 4-bit-counter instance
// share one randomized stream; a behavioural model queues expected outputs per cycle.
module tb_seq_checker;

   logic        clk_pixel = 1'b0;
   logic        rstn;
   logic        clear;
   logic        rd_en;
   logic [15:0] rd_data;

   logic        locked_a, pulse_a, locked_b, pulse_b;
   logic [31:0] errs_a, words_a;
   logic [3:0]  errs_b, words_b;
   logic [15:0] lexp_a, lgot_a, lexp_b, lgot_b;

   always #5 clk_pixel = ~clk_pixel;

   seq_checker #(.DSIZE(16), .RD_LATENCY(1), .LOCK_COUNT(8), .LOSS_COUNT(4), .CNT_W(32)) u_dut (
      .clk_pixel (clk_pixel),
      .rstn      (rstn),
      .clear     (clear),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .locked    (locked_a),
      .err_count (errs_a),
      .word_count(words_a),
      .err_pulse (pulse_a),
      .last_exp  (lexp_a),
      .last_got  (lgot_a)
   );

   seq_checker #(.DSIZE(16), .RD_LATENCY(1), .LOCK_COUNT(8), .LOSS_COUNT(4), .CNT_W(4)) u_sat (
      .clk_pixel (clk_pixel),
      .rstn      (rstn),
      .clear     (clear),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .locked    (locked_b),
      .err_count (errs_b),
      .word_count(words_b),
      .err_pulse (pulse_b),
      .last_exp  (lexp_b),
      .last_got  (lgot_b)
   );

   typedef struct {
      bit          locked;
      int unsigned errs;
      int unsigned words;
      bit          pulse;
      logic [15:0] lexp;
      logic [15:0] lgot;
   } exp_t;

   exp_t sb_q[$];
   int unsigned checks = 0;
   int unsigned errors = 0;

   // Reference model: "have a reference value", "in-sequence run length", "misses in a row".
   bit          m_ref, m_locked, m_pulse;
   int unsigned m_run, m_miss, m_errs, m_words;
   logic [15:0] m_exp, m_lexp, m_lgot;
   bit          pend_en;
   logic [15:0] pend_w;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
      end
   endtask

   function automatic int unsigned sat(input int unsigned v, input int unsigned max);
      return (v > max) ? max : v;
   endfunction

   task automatic model_clear();
      m_ref = 0; m_locked = 0; m_run = 0; m_miss = 0;
      m_errs = 0; m_words = 0; m_exp = '0; m_lexp = '0; m_lgot = '0;
   endtask

   task automatic model_word(input logic [15:0] d);
      m_words++;
      if (!m_ref) begin
         m_ref = 1;
         m_run = 1;
      end else if (!m_locked) begin
         if (d == m_exp) begin
            m_run++;
            if (m_run == 8) begin
               m_locked = 1;
               m_miss   = 0;
            end
         end else begin
            m_run = 1;
         end
      end else if (d == m_exp) begin
         m_miss = 0;
      end else begin
         m_errs++;
         m_pulse = 1;
         m_lexp  = m_exp;
         m_lgot  = d;
         m_miss++;
         if (m_miss == 4) begin
            m_locked = 0;
            m_ref    = 0;
         end
      end
      m_exp = 16'((32'(d) + 1) % 65536);
   endtask

   task automatic push_expected();
      exp_t e;
      e.locked = m_locked; e.errs = m_errs; e.words = m_words;
      e.pulse = m_pulse; e.lexp = m_lexp; e.lgot = m_lgot;
      sb_q.push_back(e);
   endtask

   // One cycle of stimulus: w is the word returned for this read one cycle later.
   task automatic step(input bit en, input logic [15:0] w, input bit clr);
      @(negedge clk_pixel);
      rstn    = 1'b1;
      rd_en   = en;
      clear   = clr;
      rd_data = pend_en ? pend_w : 16'($urandom);
      m_pulse = 0;
      if (clr) model_clear();
      else if (pend_en) model_word(pend_w);
      pend_en = en;
      pend_w  = w;
      push_expected();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_locked"}, 64'(locked_a), 64'd0);
      check({tag, "_err"},    64'(errs_a),   64'd0);
      check({tag, "_words"},  64'(words_a),  64'd0);
      check({tag, "_pulse"},  64'(pulse_a),  64'd0);
      check({tag, "_lexp"},   64'(lexp_a),   64'd0);
      check({tag, "_lgot"},   64'(lgot_a),   64'd0);
      check({tag, "_err4"},   64'(errs_b),   64'd0);
      check({tag, "_words4"}, 64'(words_b),  64'd0);
   endtask

   task automatic reset_pulse();
      @(negedge clk_pixel);
      rstn  = 1'b0;
      rd_en = 1'b0;
      clear = 1'b0;
      #1;
      check_all_zero("async_rst");
      model_clear();
      m_pulse = 0;
      pend_en = 0;
      push_expected();
   endtask

   // Monitor: every cycle the DUT presents a status word, compare it to the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_pixel);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("locked",      64'(locked_a), 64'(e.locked));
            check("err_count",   64'(errs_a),   64'(e.errs));
            check("word_count",  64'(words_a),  64'(e.words));
            check("err_pulse",   64'(pulse_a),  64'(e.pulse));
            check("last_exp",    64'(lexp_a),   64'(e.lexp));
            check("last_got",    64'(lgot_a),   64'(e.lgot));
            check("locked4",     64'(locked_b), 64'(e.locked));
            check("err_count4",  64'(errs_b),   64'(sat(e.errs, 15)));
            check("word_count4", 64'(words_b),  64'(sat(e.words, 15)));
            check("err_pulse4",  64'(pulse_b),  64'(e.pulse));
         end
      end
   end

   initial begin
      logic [15:0] w;
      int unsigned wait_cnt;
      rstn = 1'b0; clear = 1'b0; rd_en = 1'b0; rd_data = '0;
      model_clear(); m_pulse = 0; pend_en = 0; pend_w = '0;
      repeat (3) @(negedge clk_pixel);
      #1;
      check_all_zero("reset");

      // Words 0..19, rd_en held high
      for (int i = 0; i < 20; i++) step(1, 16'(i), 0);
      step(0, '0, 0);

      // Stream across the 16-bit wrap
      step(0, '0, 1);
      for (int i = 0; i < 16; i++) step(1, 16'(32'hFFF8 + i), 0);
      step(0, '0, 0);

      // Lock, then drop 0x0100: one error with last_exp=0x0100, last_got=0x0101
      step(0, '0, 1);
      for (int i = 0; i < 16; i++) step(1, 16'(32'h00F0 + i), 0);
      step(1, 16'h0101, 0);
      step(1, 16'h0102, 0);
      step(0, '0, 0);

      // Four non-sequential words lose lock, eight sequential words regain it
      w = 16'h0102;
      for (int i = 0; i < 4; i++) begin
         w = w + 16'd2 + 16'($urandom_range(0, 500));
         step(1, w, 0);
      end
      w = 16'($urandom);
      for (int i = 0; i < 8; i++) step(1, w + 16'(i), 0);
      step(0, '0, 0);

      // rd_en toggling with junk data on idle cycles
      step(0, '0, 1);
      for (int i = 0; i < 20; i++) begin
         step(1, 16'(i), 0);
         step(0, 16'($urandom), 0);
      end

      // clear coincident with a valid word, then a reset mid-stream
      for (int i = 20; i < 32; i++) step(1, 16'(i), (i == 26));
      for (int i = 32; i < 44; i++) step(1, 16'(i), 0);
      reset_pulse();
      for (int i = 100; i < 112; i++) step(1, 16'(i), 0);

      // Repeated loss of lock drives the 4-bit error counter into saturation
      step(0, '0, 1);
      w = 16'h4000;
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < 8; i++) begin
            step(1, w, 0);
            w = w + 16'd1;
         end
         for (int i = 0; i < 4; i++) begin
            w = w + 16'd3 + 16'($urandom_range(0, 50));
            step(1, w, 0);
         end
      end

      // Random stream: gaps, occasional skipped words, rare clear
      w = 16'($urandom);
      for (int i = 0; i < 400; i++) begin
         bit en;
         en = ($urandom_range(0, 3) != 0);
         if (en) begin
            w = w + (($urandom_range(0, 15) == 0) ? 16'($urandom_range(2, 9)) : 16'd1);
         end
         step(en, w, ($urandom_range(0, 99) == 0));
      end
      step(0, '0, 0);
      step(0, '0, 0);

      wait_cnt = 0;
      while (sb_q.size() > 0 && wait_cnt < 20) begin
         @(negedge clk_pixel);
         wait_cnt++;
      end
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
